word_bank: RTL
==============

# word_bank

Parametrised word source for the Lab 4 word-guessing game. It holds a fixed 16-entry ROM of 7-letter ASCII words and picks a word on request, either from a free-running LFSR or from an explicit index. It presents the word as a packed bus and evaluates letter guesses against it. It also tracks which letter positions have been revealed, and sits between the game controller (requests, guesses) and the display/scoring logic.

## Interface
- WORD_LEN, 7, letters used per word (1..7); leftmost WORD_LEN letters of each ROM entry
- NUM_WORDS, 8, active ROM entries (2, 4, 8 or 16); IDX_W = log2(NUM_WORDS)
- SEED, 8'hA5, LFSR reset value; must be nonzero
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- new_word  in  1  request a new word; sampled when state is IDLE or READY
- sel_en  in  1  with new_word: use sel_idx instead of the LFSR
- sel_idx  in  IDX_W  explicit word index
- guess_valid  in  1  guess strobe
- guess_char  in  7  guessed ASCII letter
- word_valid  out  1  ascii/word_idx hold a loaded word
- word_idx  out  IDX_W  index of the loaded word
- ascii  out  7*WORD_LEN  letter i at bits [7i+6:7i]; letter 0 is the first letter
- match_valid  out  1  one-cycle pulse; match_mask is valid
- match_mask  out  WORD_LEN  bit i set iff letter i == guessed char
- revealed  out  WORD_LEN  accumulated OR of match masks since the last load
- solved  out  1  revealed is all ones and word_valid is set

## Operation
- ROM entries 0..15: MUSTANG, WAFFLES, CHANGES, PLANETS, GIRAFFE, BLANKET, CAPTAIN, KITCHEN, DOLPHIN, JOURNEY, LANTERN, MONSTER, PICTURE, SHELTER, THUNDER, VOLCANO. All letters are uppercase 7-bit ASCII.
- LFSR: 8-bit, steps every cycle including in IDLE. Next value = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Reset value is SEED.
- FSM states:
  - IDLE: no word loaded. new_word -> LOAD.
  - LOAD: one cycle; ROM read and outputs updated. Always -> READY.
  - READY: new_word -> LOAD.
- Index captured on the edge that accepts new_word:
  - sel_en=1: index = sel_idx.
  - sel_en=0: candidate = lfsr[IDX_W-1:0]. If word_valid=1 and candidate == word_idx, index = (candidate+1) mod NUM_WORDS, so no immediate repeat. Otherwise index = candidate.
- Leaving LOAD: ascii and word_idx take the new word, word_valid=1, revealed=0.
- Entering LOAD: word_valid goes 0. ascii and word_idx hold their old values until LOAD completes.
- Guess handling: a guess with guess_valid=1 sampled while word_valid=1 produces, on the next edge:
  - match_mask = per-letter compare against the current ascii;
  - match_valid=1 for one cycle;
  - revealed |= match_mask.
  A guess with word_valid=0 is ignored: no pulse, and match_mask holds its previous value.
- Guess and new_word accepted on the same edge in READY: the guess is evaluated against the old word and its match pulse still occurs. revealed is then cleared by the load, and the clear takes priority.
- new_word during LOAD is ignored and not queued.
- solved is combinational from revealed and word_valid.

## Timing
- Reset values: state IDLE; lfsr=SEED; word_valid=0; word_idx=0; ascii=0; match_valid=0; match_mask=0; revealed=0; solved=0.
- Reset mid-LOAD or mid-guess returns everything to the reset values immediately; no pending request survives reset.
- Load latency: new_word sampled at edge k. word_valid is low after edge k and high with the new ascii after edge k+1.
- Back-to-back: new_word held high reloads every 2 cycles.
- Guess latency: guess sampled at edge k; match_valid, match_mask and revealed update at edge k+1.
- Consecutive guesses on every cycle each produce their own pulse.

## Test plan
- Reset -> all outputs zero. Release reset, no request for 20 cycles -> word_valid stays 0. A guess in this window -> no match_valid.
- new_word, sel_en=1, sel_idx=0 -> two edges later: word_valid=1, word_idx=0, ascii letters M,U,S,T,A,N,G (letter 0 = 7'h4D). Guess 'A' (7'h41) -> match_mask=7'b0010000, revealed=7'b0010000.
- Load WAFFLES (idx 1). Guess 'F' -> mask 7'b0001100. Guess 'Z' -> mask 0 with match_valid pulse. Guess W, A, L, E, S -> solved=1 after the last pulse.
- Repeat LFSR-driven new_word 200 times, with the bench mirroring the LFSR model -> word_idx never equals the previous word_idx. Each value matches the candidate/bump rule.
- new_word and guess 'C' on the same edge with CHANGES loaded -> match pulse mask 7'b0000001. revealed=0 after the load, then reflects the new word only.
- Assert rst during LOAD -> word_valid=0, state IDLE, lfsr=SEED. Subsequent LFSR picks reproduce the post-reset sequence.

Source files
------------

// File: rtl/word_bank.sv
// Word source for the word-guessing game: 16-entry ROM of 7-letter words,
// LFSR or explicit selection, per-letter guess matching and reveal tracking.
module word_bank #(
  parameter int           WORD_LEN  = 7,
  parameter int           NUM_WORDS = 8,
  parameter logic [7:0]   SEED      = 8'hA5,
  localparam int          IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_word,
  input  logic                    sel_en,
  input  logic [IDX_W-1:0]        sel_idx,
  input  logic                    guess_valid,
  input  logic [6:0]              guess_char,
  output logic                    word_valid,
  output logic [IDX_W-1:0]        word_idx,
  output logic [7*WORD_LEN-1:0]   ascii,
  output logic                    match_valid,
  output logic [WORD_LEN-1:0]     match_mask,
  output logic [WORD_LEN-1:0]     revealed,
  output logic                    solved
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]          state;
  logic [7:0]          lfsr;
  logic [7:0]          lfsr_next;
  logic [IDX_W-1:0]    pend_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic [IDX_W-1:0]    idx_next;
  logic [3:0]          rom_idx;
  logic [48:0]         rom_full;
  logic [WORD_LEN-1:0] guess_mask;
  logic                accept;
  logic                guess_take;

  // String literals are MSB-first 8-bit chars; repack so letter 0 sits at bit 0.
  function automatic logic [48:0] rom_word(input logic [3:0] idx);
    logic [55:0] s;
    logic [48:0] w;
    case (idx)
      4'd0:    s = "MUSTANG";
      4'd1:    s = "WAFFLES";
      4'd2:    s = "CHANGES";
      4'd3:    s = "PLANETS";
      4'd4:    s = "GIRAFFE";
      4'd5:    s = "BLANKET";
      4'd6:    s = "CAPTAIN";
      4'd7:    s = "KITCHEN";
      4'd8:    s = "DOLPHIN";
      4'd9:    s = "JOURNEY";
      4'd10:   s = "LANTERN";
      4'd11:   s = "MONSTER";
      4'd12:   s = "PICTURE";
      4'd13:   s = "SHELTER";
      4'd14:   s = "THUNDER";
      default: s = "VOLCANO";
    endcase
    for (int i = 0; i < 7; i++) w[7*i +: 7] = s[8*(6-i) +: 7];
    return w;
  endfunction

  assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign accept     = new_word && (state == IDLE || state == READY);
  assign guess_take = guess_valid && word_valid;
  assign cand_idx   = lfsr[IDX_W-1:0];
  assign solved     = word_valid && (&revealed);

  // Bump past the current word so an LFSR pick never repeats immediately.
  always_comb begin
    idx_next = cand_idx;
    if (sel_en)
      idx_next = sel_idx;
    else if (word_valid && cand_idx == word_idx)
      idx_next = cand_idx + 1'b1;
  end

  always_comb begin
    rom_idx                = '0;
    rom_idx[IDX_W-1:0]     = pend_idx;
    rom_full               = rom_word(rom_idx);
  end

  always_comb begin
    guess_mask = '0;
    for (int i = 0; i < WORD_LEN; i++)
      guess_mask[i] = (ascii[7*i +: 7] == guess_char);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      pend_idx    <= '0;
      word_valid  <= 1'b0;
      word_idx    <= '0;
      ascii       <= '0;
      match_valid <= 1'b0;
      match_mask  <= '0;
      revealed    <= '0;
    end else begin
      lfsr        <= lfsr_next;
      match_valid <= guess_take;
      if (guess_take)
        match_mask <= guess_mask;

      case (state)
        IDLE, READY: begin
          if (accept) begin
            state      <= LOAD;
            pend_idx   <= idx_next;
            word_valid <= 1'b0;
          end
        end
        LOAD: begin
          state      <= READY;
          ascii      <= rom_full[7*WORD_LEN-1:0];
          word_idx   <= pend_idx;
          word_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A load clears the reveal history even if a guess lands on the same edge.
      if (accept || state == LOAD)
        revealed <= '0;
      else if (guess_take)
        revealed <= revealed | guess_mask;
    end
  end

endmodule
